// File: rtl/adder_bsr_out.sv
// Output-side boundary-scan register for the N-bit adder.
// Captures {overflow, sum} into a serial chain, shifts it out on o_tdo
// (cell 0 = sum[0] at the tdo end), latches the chain on update and, in
// EXTEST, drives the latched values onto the observed pins. A saturating
// shift counter lets update report whether a full-length scan happened.
module adder_bsr_out #(
  parameter int BIT_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [BIT_WIDTH-1:0] i_sys_sum,
  input  logic                 i_sys_overflow,
  input  logic                 i_bsr_select,
  input  logic                 i_extest,
  input  logic                 i_capture_dr,
  input  logic                 i_shift_dr,
  input  logic                 i_update_dr,
  input  logic                 i_tdi,
  output logic                 o_tdo,
  output logic [BIT_WIDTH-1:0] o_pin_sum,
  output logic                 o_pin_overflow,
  output logic [7:0]           o_shift_count,
  output logic                 o_scan_ok
);

  localparam int         L       = BIT_WIDTH + 1;
  localparam logic [7:0] L_COUNT = 8'(L);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURED = 2'd1,
    ST_SHIFTING = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [L-1:0]   r_shift;
  logic [L-1:0]   r_upd;
  logic [7:0]     r_count;
  logic           r_scan_ok;

  logic           w_do_capture;
  logic           w_do_shift;
  logic           w_do_update;
  logic           w_full_scan;
  logic [L-1:0]   w_pins;

  // Decode TAP controls: ignored unless selected; capture > shift > update.
  always_comb begin
    w_do_capture = 1'b0;
    w_do_shift   = 1'b0;
    w_do_update  = 1'b0;
    if (i_bsr_select) begin
      w_do_capture = i_capture_dr;
      w_do_shift   = i_shift_dr & ~i_capture_dr;
      w_do_update  = i_update_dr & ~i_capture_dr & ~i_shift_dr;
    end else begin
      w_do_capture = 1'b0;
      w_do_shift   = 1'b0;
      w_do_update  = 1'b0;
    end
  end

  // Scan-state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: capture -> CAPTURED, shift -> SHIFTING, update -> IDLE, else hold.
  always_comb begin
    w_state_nxt = r_state;
    if (w_do_capture) begin
      w_state_nxt = ST_CAPTURED;
    end else if (w_do_shift) begin
      w_state_nxt = ST_SHIFTING;
    end else if (w_do_update) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM-derived output: an update only counts as a full scan after exactly L shifts.
  always_comb begin
    w_full_scan = 1'b0;
    case (r_state)
      ST_SHIFTING: w_full_scan = (r_count == L_COUNT);
      ST_IDLE:     w_full_scan = 1'b0;
      ST_CAPTURED: w_full_scan = 1'b0;
      default:     w_full_scan = 1'b0;
    endcase
  end

  // Scan chain, update latch, shift counter and scan-ok flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift   <= '0;
      r_upd     <= '0;
      r_count   <= 8'd0;
      r_scan_ok <= 1'b0;
    end else if (w_do_capture) begin
      r_shift <= {i_sys_overflow, i_sys_sum};
      r_count <= 8'd0;
    end else if (w_do_shift) begin
      r_shift <= {i_tdi, r_shift[L-1:1]};
      if (r_count != CNT_MAX) begin
        r_count <= r_count + 8'd1;
      end
    end else if (w_do_update) begin
      r_upd     <= r_shift;
      r_scan_ok <= w_full_scan;
    end
  end

  // Pin mux: system pass-through normally, update latch in EXTEST.
  always_comb begin
    w_pins = '0;
    if (i_extest) begin
      w_pins = r_upd;
    end else begin
      w_pins = {i_sys_overflow, i_sys_sum};
    end
  end

  assign o_tdo          = r_shift[0];
  assign o_pin_sum      = w_pins[BIT_WIDTH-1:0];
  assign o_pin_overflow = w_pins[L-1];
  assign o_shift_count  = r_count;
  assign o_scan_ok      = r_scan_ok;

endmodule

// File: tb/tb_adder_bsr_out.sv
// Scoreboard bench for adder_bsr_out: stimulus pushes expected observations
// into a queue; a monitor on the falling edge pops and compares them.
module tb_adder_bsr_out;

  localparam int BW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [BW-1:0] i_sys_sum;
  logic          i_sys_overflow;
  logic          i_bsr_select;
  logic          i_extest;
  logic          i_capture_dr;
  logic          i_shift_dr;
  logic          i_update_dr;
  logic          i_tdi;
  logic          o_tdo;
  logic [BW-1:0] o_pin_sum;
  logic          o_pin_overflow;
  logic [7:0]    o_shift_count;
  logic          o_scan_ok;

  adder_bsr_out #(.BIT_WIDTH(BW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sys_sum(i_sys_sum),
    .i_sys_overflow(i_sys_overflow), .i_bsr_select(i_bsr_select),
    .i_extest(i_extest), .i_capture_dr(i_capture_dr), .i_shift_dr(i_shift_dr),
    .i_update_dr(i_update_dr), .i_tdi(i_tdi), .o_tdo(o_tdo),
    .o_pin_sum(o_pin_sum), .o_pin_overflow(o_pin_overflow),
    .o_shift_count(o_shift_count), .o_scan_ok(o_scan_ok)
  );

  always #5 i_clk = ~i_clk;

  localparam int K_TDO = 0, K_PSUM = 1, K_POVF = 2, K_CNT = 3, K_OK = 4;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } item_t;

  item_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Monitor: every falling edge, drain and check all pending expectations.
  always @(negedge i_clk) begin
    while (sb.size() > 0) begin
      item_t it;
      logic [7:0] act;
      it = sb.pop_front();
      case (it.kind)
        K_TDO:   act = {7'd0, o_tdo};
        K_PSUM:  act = {4'd0, o_pin_sum};
        K_POVF:  act = {7'd0, o_pin_overflow};
        K_CNT:   act = o_shift_count;
        default: act = {7'd0, o_scan_ok};
      endcase
      n_vec++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, act, it.exp);
      end
    end
  end

  task automatic expect_v(input int kind, input logic [7:0] v, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = v;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_ctl();
    i_capture_dr = 1'b0;
    i_shift_dr   = 1'b0;
    i_update_dr  = 1'b0;
    i_rst        = 1'b0;
  endtask

  task automatic do_capture();
    i_capture_dr = 1'b1;
    tick();
    idle_ctl();
  endtask

  task automatic do_update();
    i_update_dr = 1'b1;
    tick();
    idle_ctl();
  endtask

  task automatic shift_in(input logic [4:0] bits);
    for (int i = 0; i < 5; i++) begin
      i_shift_dr = 1'b1;
      i_tdi      = bits[i];
      tick();
    end
    idle_ctl();
  endtask

  logic [4:0] seq;

  initial begin
    i_sys_sum = 4'h5; i_sys_overflow = 1'b0; i_bsr_select = 1'b1; i_extest = 1'b0;
    i_capture_dr = 1'b0; i_update_dr = 1'b0;

    // 1: reset wins over a shift with tdi=1
    i_rst = 1'b1; i_shift_dr = 1'b1; i_tdi = 1'b1;
    tick();
    tick();
    idle_ctl();
    expect_v(K_TDO, 8'd0, "rst_tdo");
    expect_v(K_CNT, 8'd0, "rst_count");
    expect_v(K_OK, 8'd0, "rst_scan_ok");
    expect_v(K_PSUM, 8'h05, "rst_pin_sum_pass");
    expect_v(K_POVF, 8'd0, "rst_pin_ovf_pass");
    tick();
    i_extest = 1'b1;
    expect_v(K_PSUM, 8'h00, "rst_pin_sum_extest");
    expect_v(K_POVF, 8'd0, "rst_pin_ovf_extest");
    tick();

    // 2: SAMPLE 0xB/ovf=1, tdo LSB first = 1,1,0,1,1
    i_extest = 1'b0; i_sys_sum = 4'hB; i_sys_overflow = 1'b1;
    do_capture();
    seq = 5'b11011;
    for (int i = 0; i < 5; i++) begin
      i_shift_dr = 1'b1; i_tdi = 1'b0;
      expect_v(K_TDO, {7'd0, seq[i]}, $sformatf("sample_tdo%0d", i));
      tick();
    end
    idle_ctl();
    expect_v(K_CNT, 8'd5, "sample_count");
    do_update();
    expect_v(K_OK, 8'd1, "sample_scan_ok");
    tick();

    // 3: EXTEST preload 5'b1_0110
    do_capture();
    shift_in(5'b10110);
    do_update();
    i_extest = 1'b1;
    expect_v(K_OK, 8'd1, "preload_scan_ok");
    expect_v(K_PSUM, 8'h06, "preload_pin_sum");
    expect_v(K_POVF, 8'd1, "preload_pin_ovf");
    tick();
    i_sys_sum = 4'hF; i_sys_overflow = 1'b0;
    expect_v(K_PSUM, 8'h06, "preload_sum_indep");
    expect_v(K_POVF, 8'd1, "preload_ovf_indep");
    tick();

    // 4: short scan: capture 0_1001, 3 shifts of 1 -> 1_1101
    i_sys_sum = 4'h9; i_sys_overflow = 1'b0;
    do_capture();
    for (int i = 0; i < 3; i++) begin
      i_shift_dr = 1'b1; i_tdi = 1'b1;
      tick();
    end
    idle_ctl();
    do_update();
    expect_v(K_OK, 8'd0, "short_scan_ok");
    expect_v(K_PSUM, 8'h0D, "short_pin_sum");
    expect_v(K_POVF, 8'd1, "short_pin_ovf");
    tick();
    do_capture();
    shift_in(5'b00011);
    do_update();
    expect_v(K_OK, 8'd1, "full_scan_ok");
    expect_v(K_PSUM, 8'h03, "full_pin_sum");
    expect_v(K_POVF, 8'd0, "full_pin_ovf");
    tick();

    // 5a: capture+shift together -> capture wins
    i_extest = 1'b0; i_sys_sum = 4'h3; i_sys_overflow = 1'b0;
    i_capture_dr = 1'b1; i_shift_dr = 1'b1; i_tdi = 1'b1;
    tick();
    idle_ctl();
    expect_v(K_CNT, 8'd0, "simul_count");
    expect_v(K_TDO, 8'd1, "simul_tdo");
    do_update();
    expect_v(K_OK, 8'd0, "simul_upd_from_captured");
    tick();

    // 5b: deselected controls are ignored
    i_extest = 1'b1; i_sys_sum = 4'hA; i_sys_overflow = 1'b1;
    do_capture();
    i_shift_dr = 1'b1; i_tdi = 1'b0;
    tick();
    idle_ctl();
    i_bsr_select = 1'b0; i_sys_sum = 4'h5; i_sys_overflow = 1'b0;
    i_capture_dr = 1'b1; i_shift_dr = 1'b1; i_update_dr = 1'b1;
    tick();
    idle_ctl();
    i_bsr_select = 1'b1;
    expect_v(K_CNT, 8'd1, "desel_count");
    expect_v(K_TDO, 8'd1, "desel_tdo");
    expect_v(K_PSUM, 8'h03, "desel_pin_sum");
    expect_v(K_POVF, 8'd0, "desel_pin_ovf");
    tick();
    do_update();
    expect_v(K_PSUM, 8'h0D, "after_desel_pin_sum");
    expect_v(K_OK, 8'd0, "after_desel_scan_ok");
    tick();

    // 6: saturation then reset mid-shift
    do_capture();
    shift_in(5'b00000);
    do_update();
    expect_v(K_OK, 8'd1, "presat_scan_ok");
    tick();
    do_capture();
    for (int i = 0; i < 300; i++) begin
      i_shift_dr = 1'b1; i_tdi = 1'b1;
      tick();
    end
    idle_ctl();
    expect_v(K_CNT, 8'd255, "sat_count");
    expect_v(K_OK, 8'd1, "sat_scan_ok_held");
    tick();
    i_shift_dr = 1'b1; i_tdi = 1'b1; i_rst = 1'b1;
    tick();
    idle_ctl();
    expect_v(K_CNT, 8'd0, "midrst_count");
    expect_v(K_TDO, 8'd0, "midrst_tdo");
    expect_v(K_OK, 8'd0, "midrst_scan_ok");
    expect_v(K_PSUM, 8'h00, "midrst_pin_sum");
    tick();
    do_update();
    expect_v(K_OK, 8'd0, "post_rst_update");
    tick();
    shift_in(5'b00000);
    do_update();
    expect_v(K_OK, 8'd1, "post_rst_full_scan");
    tick();

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
